// File: rtl/collision_pkg.sv
// Shared types and code-space helpers for the collision event scheduler.
package collision_pkg;

    localparam int unsigned NUM_FIXED_EVENTS  = 3;
    localparam int unsigned NUM_SHOTS_DEFAULT = 3;
    localparam int unsigned NUM_EVENTS        = NUM_FIXED_EVENTS + 2 * NUM_SHOTS_DEFAULT;
    localparam int unsigned SHOT_ENEMY_BASE   = NUM_FIXED_EVENTS;

    typedef enum logic [3:0] {
        EvTowerPlayer  = 4'd0,
        EvTowerEnemyHu = 4'd1,
        EvShotHd       = 4'd2,
        EvShotEnemy0   = 4'd3
    } event_code_e;

    typedef enum logic {
        StIdle,
        StPresent
    } disp_state_e;

    function automatic int unsigned num_events(int unsigned num_shots);
        return NUM_FIXED_EVENTS + 2 * num_shots;
    endfunction

    function automatic int unsigned shot_box_base(int unsigned num_shots);
        return SHOT_ENEMY_BASE + num_shots;
    endfunction

endpackage

// File: rtl/collision_prio_enc.sv
// Lowest-set-bit priority encoder: index of the lowest set bit plus an any-set flag.
module collision_prio_enc #(
    parameter int unsigned Width = 9,
    parameter int unsigned IdxW  = 4
) (
    input  logic [Width-1:0] vec_i,
    output logic [IdxW-1:0]  idx_o,
    output logic             valid_o
);

    // Scan downwards so the lowest set bit is the last one written.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = Width - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o   = IdxW'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/collision_event_scheduler.sv
// Banks per-frame collision events and dispatches the closed frame over valid/ready.
// Optional accepted-event counter enabled by defining COLLISION_STATS_EN.
module collision_event_scheduler
    import collision_pkg::*;
#(
    parameter int unsigned NUM_SHOTS = 3,
    parameter int unsigned EVT_W     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 startOfFrame,
    input  logic                 towerPlayerCollision,
    input  logic                 TowerEnemyHUCollision,
    input  logic                 ShotHeadsDownCollision,
    input  logic [NUM_SHOTS-1:0] ShotEnemyCollision,
    input  logic [NUM_SHOTS-1:0] ShotBoxCollision,
    input  logic                 event_ready,
    output logic                 event_valid,
    output logic [EVT_W-1:0]     event_id,
    output logic                 overflow,
    output logic                 busy
`ifdef COLLISION_STATS_EN
    ,
    output logic [7:0]           event_count
`endif
);

    localparam int unsigned NE = num_events(NUM_SHOTS);

    logic [NE-1:0]    in_vec;
    logic [NE-1:0]    capture_q, capture_d;
    logic [NE-1:0]    pending_q, pending_d;
    logic [NE-1:0]    acc_mask;
    logic [NE-1:0]    pend_after_acc;
    logic             overflow_q, overflow_d;
    logic             valid_q;
    logic [EVT_W-1:0] id_q;
    logic             accept;
    logic [EVT_W-1:0] enc_idx;
    logic             enc_valid;
    disp_state_e      state_q;

    // Bit position equals event code.
    assign in_vec = {ShotBoxCollision, ShotEnemyCollision, ShotHeadsDownCollision,
                     TowerEnemyHUCollision, towerPlayerCollision};

    assign accept = valid_q & event_ready;

    always_comb begin
        acc_mask       = accept ? (NE'(1) << id_q) : '0;
        pend_after_acc = pending_q & ~acc_mask;
        pending_d      = pend_after_acc;
        capture_d      = capture_q | in_vec;
        overflow_d     = 1'b0;
        // Same-cycle inputs belong to the frame being closed.
        if (startOfFrame) begin
            pending_d  = pend_after_acc | capture_q | in_vec;
            capture_d  = '0;
            overflow_d = |pend_after_acc;
        end
    end

    // Encoding the next pending value lets the first event appear right after the boundary.
    collision_prio_enc #(
        .Width (NE),
        .IdxW  (EVT_W)
    ) u_prio_enc (
        .vec_i   (pending_d),
        .idx_o   (enc_idx),
        .valid_o (enc_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            valid_q    <= 1'b0;
            id_q       <= EVT_W'(EvTowerPlayer);
            overflow_q <= 1'b0;
            capture_q  <= '0;
            pending_q  <= '0;
        end else begin
            capture_q  <= capture_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            case (state_q)
                StIdle: begin
                    if (enc_valid) begin
                        state_q <= StPresent;
                        valid_q <= 1'b1;
                        id_q    <= enc_idx;
                    end
                end
                StPresent: begin
                    // A stalled presentation is never replaced, even by a higher-priority merge.
                    if (event_ready) begin
                        if (enc_valid) begin
                            id_q <= enc_idx;
                        end else begin
                            state_q <= StIdle;
                            valid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign event_valid = valid_q;
    assign event_id    = id_q;
    assign overflow    = overflow_q;
    assign busy        = |pending_q;

`ifdef COLLISION_STATS_EN
    logic [7:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 8'd0;
        end else if (accept && (count_q != 8'hFF)) begin
            count_q <= count_q + 8'd1;
        end
    end

    assign event_count = count_q;
`endif

endmodule

// File: tb/tb_collision_event_scheduler.sv
// Randomized and directed bench for collision_event_scheduler against a set-based frame model.
module tb_collision_event_scheduler;

    localparam int NS = 3;
    localparam int NE = 3 + 2 * NS;

    logic          clk = 1'b0;
    logic          reset, sof, tp, teh, shd, ready;
    logic [NS-1:0] se, sb;
    logic          valid;
    logic [3:0]    id;
    logic          ovf, busy;
`ifdef COLLISION_STATS_EN
    logic [7:0]    cnt;
`endif

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model: sets of events open in the current frame and awaiting dispatch.
    bit m_cap[NE];
    bit m_pend[NE];
    bit m_valid;
    int m_id;
    bit m_ovf;
    int m_cnt;

    always #5 clk = ~clk;

    collision_event_scheduler #(
        .NUM_SHOTS (NS),
        .EVT_W     (4)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .startOfFrame           (sof),
        .towerPlayerCollision   (tp),
        .TowerEnemyHUCollision  (teh),
        .ShotHeadsDownCollision (shd),
        .ShotEnemyCollision     (se),
        .ShotBoxCollision       (sb),
        .event_ready            (ready),
        .event_valid            (valid),
        .event_id               (id),
        .overflow               (ovf),
        .busy                   (busy)
`ifdef COLLISION_STATS_EN
        ,
        .event_count            (cnt)
`endif
    );

    function automatic bit any_pend();
        for (int i = 0; i < NE; i++) if (m_pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int lowest_pend();
        for (int i = 0; i < NE; i++) if (m_pend[i]) return i;
        return 0;
    endfunction

    task automatic clear_inputs();
        sof = 1'b0; tp = 1'b0; teh = 1'b0; shd = 1'b0; se = '0; sb = '0;
    endtask

    // Advance one clock; the model consumes the inputs seen at the edge.
    task automatic tick();
        bit src[NE];
        bit acc;
        @(posedge clk);
        src[0] = tp; src[1] = teh; src[2] = shd;
        for (int i = 0; i < NS; i++) begin
            src[3 + i]      = se[i];
            src[3 + NS + i] = sb[i];
        end
        if (reset) begin
            for (int i = 0; i < NE; i++) begin m_cap[i] = 1'b0; m_pend[i] = 1'b0; end
            m_valid = 1'b0; m_id = 0; m_ovf = 1'b0; m_cnt = 0;
        end else begin
            acc = m_valid && ready;
            if (acc) begin
                m_pend[m_id] = 1'b0;
                if (m_cnt < 255) m_cnt++;
            end
            m_ovf = sof && any_pend();
            for (int i = 0; i < NE; i++) begin
                if (sof) begin
                    m_pend[i] = m_pend[i] | m_cap[i] | src[i];
                    m_cap[i]  = 1'b0;
                end else begin
                    m_cap[i] = m_cap[i] | src[i];
                end
            end
            if (!m_valid || acc) begin
                m_valid = any_pend();
                if (m_valid) m_id = lowest_pend();
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; ready = 1'b0; clear_inputs();
        tick(); tick();
        n_vec++;
        if ({valid, id, ovf, busy} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got valid=%b id=%0d ovf=%b busy=%b want all 0",
                     valid, id, ovf, busy);
        end
        reset = 1'b0;
        tick();
        n_vec++;
        if ({valid, busy} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_idle: got valid=%b busy=%b want 0 0", valid, busy);
        end
    endtask

    task automatic test_single();
        tp = 1'b1;
        repeat (5) tick();
        tp = 1'b0; ready = 1'b1; sof = 1'b1;
        tick();
        sof = 1'b0;
        n_vec++;
        if ({valid, id, busy} !== {1'b1, 4'd0, 1'b1}) begin
            n_err++;
            $display("FAIL single_present: got valid=%b id=%0d busy=%b want 1 0 1", valid, id, busy);
        end
        tick();
        n_vec++;
        if ({valid, busy} !== 2'b00) begin
            n_err++;
            $display("FAIL single_drain: got valid=%b busy=%b want 0 0", valid, busy);
        end
        repeat (3) begin
            tick();
            n_vec++;
            if (valid !== 1'b0) begin
                n_err++;
                $display("FAIL single_once: got valid=%b want 0", valid);
            end
        end
    endtask

    task automatic test_back_to_back(input int stall);
        int exp_ids[3];
        exp_ids[0] = 3; exp_ids[1] = 5; exp_ids[2] = 7;
        se = 3'b101; sb = 3'b010;
        tick();
        clear_inputs();
        ready = (stall == 0); sof = 1'b1;
        tick();
        sof = 1'b0;
        for (int k = 0; k < stall; k++) begin
            n_vec++;
            if ({valid, id} !== {1'b1, 4'd3}) begin
                n_err++;
                $display("FAIL stall_hold: got valid=%b id=%0d want 1 3", valid, id);
            end
            tick();
        end
        ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            n_vec++;
            if ({valid, id} !== {1'b1, 4'(exp_ids[j])}) begin
                n_err++;
                $display("FAIL b2b_seq%0d: got valid=%b id=%0d want 1 %0d", j, valid, id, exp_ids[j]);
            end
            tick();
        end
        n_vec++;
        if ({valid, busy} !== 2'b00) begin
            n_err++;
            $display("FAIL b2b_end: got valid=%b busy=%b want 0 0", valid, busy);
        end
    endtask

    task automatic test_overflow();
        se = 3'b101; sb = 3'b010;
        tick();
        clear_inputs();
        ready = 1'b1; sof = 1'b1;
        tick();            // id 3 presented
        sof = 1'b0;
        tick();            // id 5 presented
        tick();            // id 7 presented
        ready = 1'b0;
        shd = 1'b1;
        tick();
        shd = 1'b0;
        tick();
        sof = 1'b1;
        tick();
        sof = 1'b0;
        n_vec++;
        if ({ovf, valid, id, busy} !== {1'b1, 1'b1, 4'd7, 1'b1}) begin
            n_err++;
            $display("FAIL ovf_pulse: got ovf=%b valid=%b id=%0d busy=%b want 1 1 7 1",
                     ovf, valid, id, busy);
        end
        tick();
        n_vec++;
        if ({ovf, valid, id} !== {1'b0, 1'b1, 4'd7}) begin
            n_err++;
            $display("FAIL ovf_one_cycle: got ovf=%b valid=%b id=%0d want 0 1 7", ovf, valid, id);
        end
        ready = 1'b1;
        tick();
        n_vec++;
        if ({valid, id} !== {1'b1, 4'd2}) begin
            n_err++;
            $display("FAIL ovf_merged: got valid=%b id=%0d want 1 2", valid, id);
        end
        tick();
        n_vec++;
        if ({valid, busy} !== 2'b00) begin
            n_err++;
            $display("FAIL ovf_drain: got valid=%b busy=%b want 0 0", valid, busy);
        end
    endtask

    task automatic test_sof_cycle();
        shd = 1'b1; sof = 1'b1; ready = 1'b1;
        tick();
        clear_inputs();
        n_vec++;
        if ({valid, id} !== {1'b1, 4'd2}) begin
            n_err++;
            $display("FAIL sof_same_cycle: got valid=%b id=%0d want 1 2", valid, id);
        end
        tick();
        n_vec++;
        if (valid !== 1'b0) begin
            n_err++;
            $display("FAIL sof_same_drain: got valid=%b want 0", valid);
        end
        // Back-to-back boundaries while the event is stalled.
        ready = 1'b0; tp = 1'b1;
        tick();
        tp = 1'b0; sof = 1'b1;
        tick();
        n_vec++;
        if ({ovf, valid, id} !== {1'b0, 1'b1, 4'd0}) begin
            n_err++;
            $display("FAIL sof_first: got ovf=%b valid=%b id=%0d want 0 1 0", ovf, valid, id);
        end
        tick();
        sof = 1'b0;
        n_vec++;
        if ({ovf, valid, id} !== {1'b1, 1'b1, 4'd0}) begin
            n_err++;
            $display("FAIL sof_second: got ovf=%b valid=%b id=%0d want 1 1 0", ovf, valid, id);
        end
        ready = 1'b1;
        tick();
        tick();
        n_vec++;
        if ({ovf, valid, busy} !== 3'b000) begin
            n_err++;
            $display("FAIL sof_dup_collapse: got ovf=%b valid=%b busy=%b want 0 0 0", ovf, valid, busy);
        end
    endtask

    task automatic test_reset_mid();
        tp = 1'b1;
        tick();
        tp = 1'b0; ready = 1'b0; sof = 1'b1;
        tick();
        sof = 1'b0;
        reset = 1'b1; ready = 1'b1;
        tick();
        reset = 1'b0; ready = 1'b0;
        n_vec++;
        if ({valid, busy, ovf} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_mid: got valid=%b busy=%b ovf=%b want 0 0 0", valid, busy, ovf);
        end
        tick();
        n_vec++;
        if (valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_after: got valid=%b want 0", valid);
        end
    endtask

    task automatic test_random();
        reset = 1'b1; clear_inputs();
        tick();
        reset = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            tp    = ($urandom_range(15) == 0);
            teh   = ($urandom_range(15) == 0);
            shd   = ($urandom_range(15) == 0);
            for (int i = 0; i < NS; i++) begin
                se[i] = ($urandom_range(15) == 0);
                sb[i] = ($urandom_range(15) == 0);
            end
            sof   = ($urandom_range(19) == 0);
            ready = ($urandom_range(3) != 0);
            reset = ($urandom_range(799) == 0);
            tick();
            n_vec++;
            if (valid !== m_valid) begin
                n_err++;
                $display("FAIL rand_valid@%0d: got %b want %b", c, valid, m_valid);
            end
            if (m_valid) begin
                n_vec++;
                if (id !== 4'(m_id)) begin
                    n_err++;
                    $display("FAIL rand_id@%0d: got %0d want %0d", c, id, m_id);
                end
            end
            n_vec++;
            if ({ovf, busy} !== {m_ovf, any_pend()}) begin
                n_err++;
                $display("FAIL rand_ovf_busy@%0d: got ovf=%b busy=%b want %b %b",
                         c, ovf, busy, m_ovf, any_pend());
            end
`ifdef COLLISION_STATS_EN
            n_vec++;
            if (cnt !== 8'(m_cnt)) begin
                n_err++;
                $display("FAIL rand_count@%0d: got %0d want %0d", c, cnt, m_cnt);
            end
`endif
        end
        reset = 1'b0; clear_inputs();
    endtask

`ifdef COLLISION_STATS_EN
    task automatic test_stats();
        reset = 1'b1;
        tick();
        reset = 1'b0; ready = 1'b1;
        repeat (34) begin
            tp = 1'b1; teh = 1'b1; shd = 1'b1; se = '1; sb = '1;
            tick();
            clear_inputs();
            sof = 1'b1;
            tick();
            sof = 1'b0;
            repeat (10) tick();
        end
        n_vec++;
        if (cnt !== 8'd255) begin
            n_err++;
            $display("FAIL stats_saturate: got %0d want 255", cnt);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_vec++;
        if (cnt !== 8'd0) begin
            n_err++;
            $display("FAIL stats_reset: got %0d want 0", cnt);
        end
    endtask
`endif

    initial begin
        reset = 1'b1; ready = 1'b0; clear_inputs();
        test_reset();
        test_single();
        test_back_to_back(0);
        test_back_to_back(10);
        test_overflow();
        test_sof_cycle();
        test_reset_mid();
        test_random();
`ifdef COLLISION_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
